// File: rtl/fv_info_pkg.sv
// -----------------------------------------------------------------------------
// fv_info_pkg
// Shared sizing constants, types and helpers for the FV-info request issuer.
//   NUM_PE     requesting PEs
//   NODE_ID_W  node index width (FV-info SRAM is 128 deep)
//   INFO_W     FV-info word width
//   MAX_OUTST  in-flight request cap and tag FIFO depth (power of 2, >= 2)
// -----------------------------------------------------------------------------
package fv_info_pkg;

  localparam int NUM_PE    = 4;
  localparam int NODE_ID_W = 7;
  localparam int INFO_W    = 10;
  localparam int MAX_OUTST = 4;
  localparam int PE_ID_W   = $clog2(NUM_PE);
  localparam int CNT_W     = $clog2(MAX_OUTST) + 1;

  typedef logic [PE_ID_W-1:0]   fv_pe_id_t;
  typedef logic [NODE_ID_W-1:0] fv_node_id_t;
  typedef logic [INFO_W-1:0]    fv_info_t;

  typedef struct packed {
    logic        valid;
    fv_pe_id_t   pe_id;
    fv_node_id_t node_id;
  } fv_info_bus_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fv_issuer_state_e;

  // Round-robin successor; explicit wrap keeps it correct for non-power-of-2 NUM_PE.
  function automatic fv_pe_id_t rr_next(input fv_pe_id_t id);
    return (id == fv_pe_id_t'(NUM_PE - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/fv_info_tag_fifo.sv
// -----------------------------------------------------------------------------
// fv_info_tag_fifo
// Synchronous FIFO holding the pe_id of every granted request until its
// in-order response returns. Pointers are PTR_W+1 bits; full/empty are told
// apart by the pointer MSB.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i, push_data_i   enqueue a tag (ignored when full)
//   pop_i            dequeue the head tag (ignored when empty)
//   head_o           oldest tag
//   full_o, empty_o  occupancy flags
//   count_o          number of stored tags
// -----------------------------------------------------------------------------
module fv_info_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/fv_info_req_issuer.sv
// -----------------------------------------------------------------------------
// fv_info_req_issuer
// Initiator side of the FV-info lookup path. Arbitrates round-robin among
// NUM_PE requesters, drives one {valid,pe_id,node_id} beat per bus grant and
// steers each in-order response back to its PE via a tag FIFO. In-flight
// requests are capped at MAX_OUTST.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   pe_req_valid/pe_req_node   per-PE request (held until accepted)
//   pe_req_ready               one-hot, one-cycle accept pulse
//   bus_req_valid/pe_id/node   request beat; transfers on bus_gnt
//   bus_gnt                    bus grant
//   rsp_valid/rsp_data         in-order response, no backpressure
//   pe_info_valid/pe_info_data registered response delivery
//   outst_cnt                  in-flight request count
//   rsp_err                    sticky protocol error
// Build option: define FV_INFO_RSP_CHECK_EN to build the rsp_err checker
// (unexpected response, grant without a request). Otherwise rsp_err is 0.
// -----------------------------------------------------------------------------
module fv_info_req_issuer
  import fv_info_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PE-1:0]           pe_req_valid,
  input  logic [NUM_PE*NODE_ID_W-1:0] pe_req_node,
  output logic [NUM_PE-1:0]           pe_req_ready,
  output logic                        bus_req_valid,
  output logic [PE_ID_W-1:0]          bus_req_pe_id,
  output logic [NODE_ID_W-1:0]        bus_req_node,
  input  logic                        bus_gnt,
  input  logic                        rsp_valid,
  input  logic [INFO_W-1:0]           rsp_data,
  output logic [NUM_PE-1:0]           pe_info_valid,
  output logic [INFO_W-1:0]           pe_info_data,
  output logic [CNT_W-1:0]            outst_cnt,
  output logic                        rsp_err
);

  fv_issuer_state_e  state_q, state_d;
  fv_pe_id_t         rr_ptr_q, rr_ptr_d;
  fv_info_bus_req_t  bus_req_q, bus_req_d;
  logic [NUM_PE-1:0] pe_req_ready_q, pe_req_ready_d;
  logic [NUM_PE-1:0] pe_info_valid_q, pe_info_valid_d;
  fv_info_t          pe_info_data_q, pe_info_data_d;

  logic              tag_push, tag_pop, tag_full, tag_empty;
  fv_pe_id_t         tag_head;
  logic [CNT_W-1:0]  tag_count;

  fv_pe_id_t         arb_idx, winner;
  logic              winner_found;

  assign tag_push = bus_req_q.valid && bus_gnt;
  assign tag_pop  = rsp_valid && !tag_empty;

  fv_info_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (PE_ID_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (tag_push),
    .push_data_i (bus_req_q.pe_id),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (tag_count)
  );

  // First requester at or after the round-robin pointer.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    arb_idx      = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      arb_idx = fv_pe_id_t'((int'(rr_ptr_q) + i) % NUM_PE);
      if (!winner_found && pe_req_valid[arb_idx]) begin
        winner       = arb_idx;
        winner_found = 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    bus_req_d      = bus_req_q;
    pe_req_ready_d = '0;
    unique case (state_q)
      IDLE: begin
        // Full check is made only here, so a beat already in REQ may finish.
        if (winner_found && !tag_full) begin
          state_d           = REQ;
          bus_req_d.valid   = 1'b1;
          bus_req_d.pe_id   = winner;
          bus_req_d.node_id = pe_req_node[int'(winner)*NODE_ID_W +: NODE_ID_W];
          pe_req_ready_d[winner] = 1'b1;
          rr_ptr_d          = rr_next(winner);
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d         = IDLE;
          bus_req_d.valid = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pe_info_valid_d = '0;
    pe_info_data_d  = pe_info_data_q;
    if (tag_pop) begin
      pe_info_valid_d[tag_head] = 1'b1;
      pe_info_data_d            = rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      bus_req_q       <= '0;
      pe_req_ready_q  <= '0;
      pe_info_valid_q <= '0;
      pe_info_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      bus_req_q       <= bus_req_d;
      pe_req_ready_q  <= pe_req_ready_d;
      pe_info_valid_q <= pe_info_valid_d;
      pe_info_data_q  <= pe_info_data_d;
    end
  end

`ifdef FV_INFO_RSP_CHECK_EN
  logic rsp_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
    end else if ((rsp_valid && tag_empty) || (bus_gnt && !bus_req_q.valid)) begin
      rsp_err_q <= 1'b1;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign pe_req_ready  = pe_req_ready_q;
  assign bus_req_valid = bus_req_q.valid;
  assign bus_req_pe_id = bus_req_q.pe_id;
  assign bus_req_node  = bus_req_q.node_id;
  assign pe_info_valid = pe_info_valid_q;
  assign pe_info_data  = pe_info_data_q;
  assign outst_cnt     = tag_count;

endmodule

// File: tb/tb_fv_info_req_issuer.sv
// -----------------------------------------------------------------------------
// tb_fv_info_req_issuer
// Self-checking bench for fv_info_req_issuer. A transaction-level reference
// (pending beat + queue of outstanding tags) predicts every output each cycle;
// directed phases cover the documented scenarios, then a randomized phase
// exercises arbitration, grant stalls, responses and tag FIFO wrap-around.
// -----------------------------------------------------------------------------
module tb_fv_info_req_issuer;
  import fv_info_pkg::*;

`ifdef FV_INFO_RSP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_PE-1:0]           pe_req_valid;
  logic [NUM_PE*NODE_ID_W-1:0] pe_req_node;
  logic [NUM_PE-1:0]           pe_req_ready;
  logic                        bus_req_valid;
  logic [PE_ID_W-1:0]          bus_req_pe_id;
  logic [NODE_ID_W-1:0]        bus_req_node;
  logic                        bus_gnt;
  logic                        rsp_valid;
  logic [INFO_W-1:0]           rsp_data;
  logic [NUM_PE-1:0]           pe_info_valid;
  logic [INFO_W-1:0]           pe_info_data;
  logic [CNT_W-1:0]            outst_cnt;
  logic                        rsp_err;

  fv_info_req_issuer dut (
    .clk           (clk),
    .reset         (reset),
    .pe_req_valid  (pe_req_valid),
    .pe_req_node   (pe_req_node),
    .pe_req_ready  (pe_req_ready),
    .bus_req_valid (bus_req_valid),
    .bus_req_pe_id (bus_req_pe_id),
    .bus_req_node  (bus_req_node),
    .bus_gnt       (bus_gnt),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .pe_info_valid (pe_info_valid),
    .pe_info_data  (pe_info_data),
    .outst_cnt     (outst_cnt),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  bit                m_busy;
  int                m_pe;
  int                m_node;
  int                m_rr;
  int                tag_q[$];
  logic [NUM_PE-1:0] m_ready;
  logic [NUM_PE-1:0] m_info_valid;
  logic [INFO_W-1:0] m_info_data;
  bit                m_err;

  bit  log_issues;
  int  issue_log[$];

  task automatic model_reset();
    m_busy = 0; m_pe = 0; m_node = 0; m_rr = 0;
    tag_q.delete();
    m_ready = '0; m_info_valid = '0; m_info_data = '0; m_err = 0;
  endtask

  // Predict the state after the coming clock edge from the current inputs.
  task automatic model_edge();
    bit push, pop, found;
    int w;
    push = m_busy && bus_gnt;
    pop  = rsp_valid && (tag_q.size() != 0);
    if (ERR_EN && ((rsp_valid && tag_q.size() == 0) || (bus_gnt && !m_busy))) m_err = 1;
    m_info_valid = '0;
    if (pop) begin
      m_info_valid[tag_q[0]] = 1'b1;
      m_info_data = rsp_data;
    end
    m_ready = '0;
    if (!m_busy) begin
      if (pe_req_valid != '0 && tag_q.size() < MAX_OUTST) begin
        found = 0; w = 0;
        for (int k = 0; k < NUM_PE; k++) begin
          if (!found && pe_req_valid[(m_rr + k) % NUM_PE]) begin
            found = 1;
            w = (m_rr + k) % NUM_PE;
          end
        end
        m_busy = 1;
        m_pe   = w;
        m_node = int'(pe_req_node[w*NODE_ID_W +: NODE_ID_W]);
        m_ready[w] = 1'b1;
        m_rr   = (w + 1) % NUM_PE;
      end
    end else if (push) begin
      m_busy = 0;
    end
    if (pop)  tag_q.delete(0);
    if (push) tag_q.push_back(m_pe);
  endtask

  task automatic compare_all();
    check("bus_req_valid", 32'(bus_req_valid), 32'(m_busy));
    if (m_busy) begin
      check("bus_req_pe_id", 32'(bus_req_pe_id), 32'(m_pe));
      check("bus_req_node",  32'(bus_req_node),  32'(m_node));
    end
    check("pe_req_ready",  32'(pe_req_ready),  32'(m_ready));
    check("pe_info_valid", 32'(pe_info_valid), 32'(m_info_valid));
    check("pe_info_data",  32'(pe_info_data),  32'(m_info_data));
    check("outst_cnt",     32'(outst_cnt),     32'(tag_q.size()));
    check("rsp_err",       32'(rsp_err),       32'(m_err));
  endtask

  // One clock: inputs already driven; outputs compared 1 time unit after the edge.
  task automatic step();
    if (log_issues && bus_req_valid && bus_gnt) issue_log.push_back(int'(bus_req_pe_id));
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // PE agents: a PE whose request was just accepted, or which is idle, raises a
  // new request with probability prob percent; pending requests are held.
  task automatic pe_update(input int prob);
    for (int i = 0; i < NUM_PE; i++) begin
      if (m_ready[i] || !pe_req_valid[i]) begin
        pe_req_valid[i] = ($urandom_range(0, 99) < prob);
        pe_req_node[i*NODE_ID_W +: NODE_ID_W] = fv_node_id_t'($urandom_range(0, 127));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pe_req_valid = '0; pe_req_node = '0;
    bus_gnt = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int oldest;
    log_issues = 0;

    // ---- Reset state --------------------------------------------------------
    do_reset();

    // ---- Single request: PE2, node 0x15, grant tied high -------------------
    bus_gnt = 1'b1;
    pe_req_valid = 4'b0100;
    pe_req_node[2*NODE_ID_W +: NODE_ID_W] = 7'h15;
    step();
    check("single_valid", 32'(bus_req_valid), 32'd1);
    check("single_pe_id", 32'(bus_req_pe_id), 32'd2);
    check("single_node",  32'(bus_req_node),  32'h15);
    check("single_ready", 32'(pe_req_ready),  32'b0100);
    pe_update(0);
    step();
    check("single_outst", 32'(outst_cnt), 32'd1);
    rsp_valid = 1'b1; rsp_data = 10'h3A5;
    step();
    rsp_valid = 1'b0;
    check("single_info_valid", 32'(pe_info_valid), 32'b0100);
    check("single_info_data",  32'(pe_info_data),  32'h3A5);
    check("single_outst_after", 32'(outst_cnt), 32'd0);
    step();

    // ---- Round robin: all PEs request continuously --------------------------
    do_reset();
    pe_req_valid = '1;
    for (int i = 0; i < NUM_PE; i++) pe_req_node[i*NODE_ID_W +: NODE_ID_W] = fv_node_id_t'(i + 8);
    bus_gnt = 1'b1;
    issue_log.delete();
    log_issues = 1;
    for (int c = 0; c < 14; c++) begin
      rsp_valid = (tag_q.size() != 0);
      rsp_data  = fv_info_t'($urandom);
      step();
      pe_update(100);
    end
    log_issues = 0;
    rsp_valid = 1'b0;
    check("rr_issue_count", 32'(issue_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < issue_log.size()) check("rr_order", 32'(issue_log[i]), 32'(exp_order[i]));

    // ---- Full stall: four grants, no responses ------------------------------
    do_reset();
    pe_req_valid = '1;
    bus_gnt = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      pe_update(100);
    end
    check("full_outst", 32'(outst_cnt), 32'd4);
    check("full_no_ready", 32'(pe_req_ready), 32'd0);
    check("full_no_beat", 32'(bus_req_valid), 32'd0);
    rsp_valid = 1'b1; rsp_data = fv_info_t'($urandom);
    step();
    rsp_valid = 1'b0;
    pe_update(100);
    check("full_outst_pop", 32'(outst_cnt), 32'd3);
    step();
    check("full_resume_beat", 32'(bus_req_valid), 32'd1);
    pe_update(100);
    step();
    pe_update(100);
    check("full_outst_refill", 32'(outst_cnt), 32'd4);

    // ---- Grant wait: bus_gnt low for 5 cycles -------------------------------
    do_reset();
    pe_req_valid = 4'b0010;
    pe_req_node[1*NODE_ID_W +: NODE_ID_W] = 7'h5A;
    step();
    pe_update(0);
    for (int c = 0; c < 5; c++) begin
      check("wait_valid", 32'(bus_req_valid), 32'd1);
      check("wait_pe_id", 32'(bus_req_pe_id), 32'd1);
      check("wait_node",  32'(bus_req_node),  32'h5A);
      check("wait_outst", 32'(outst_cnt), 32'd0);
      if (c < 4) step();
    end
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("wait_outst_grant", 32'(outst_cnt), 32'd1);
    check("wait_valid_drop", 32'(bus_req_valid), 32'd0);

    // ---- Same-cycle grant and response at outst_cnt = 2 ---------------------
    do_reset();
    pe_req_valid = '1;
    for (int c = 0; c < 20; c++) begin
      if (m_busy && tag_q.size() == 2) break;
      bus_gnt = m_busy;
      step();
      pe_update(100);
    end
    check("same_setup_outst", 32'(outst_cnt), 32'd2);
    oldest = (tag_q.size() != 0) ? tag_q[0] : 0;
    bus_gnt = 1'b1; rsp_valid = 1'b1; rsp_data = 10'h2C3;
    step();
    bus_gnt = 1'b0; rsp_valid = 1'b0;
    check("same_outst", 32'(outst_cnt), 32'd2);
    check("same_info_valid", 32'(pe_info_valid), 32'(1 << oldest));
    check("same_info_data", 32'(pe_info_data), 32'h2C3);

    // ---- Randomized traffic (many issues, FIFO wraps) -----------------------
    for (int c = 0; c < 1500; c++) begin
      pe_update(30);
      bus_gnt   = ($urandom_range(0, 99) < 60);
      rsp_valid = ((tag_q.size() != 0) && ($urandom_range(0, 99) < 40)) ||
                  ($urandom_range(0, 99) < 2);
      rsp_data  = fv_info_t'($urandom);
      step();
    end

    // ---- Unexpected response with nothing in flight -------------------------
    do_reset();
    rsp_valid = 1'b1; rsp_data = 10'h155;
    step();
    rsp_valid = 1'b0;
    check("err_no_info", 32'(pe_info_valid), 32'd0);
    check("err_outst", 32'(outst_cnt), 32'd0);
    check("err_flag", 32'(rsp_err), 32'(ERR_EN));
    step();
    check("err_sticky", 32'(rsp_err), 32'(ERR_EN));

    // ---- Reset asserted mid-REQ ---------------------------------------------
    do_reset();
    pe_req_valid = 4'b0001;
    pe_req_node[0 +: NODE_ID_W] = 7'h33;
    step();
    pe_update(0);
    check("midreq_valid", 32'(bus_req_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midreq_rst_valid", 32'(bus_req_valid), 32'd0);
    check("midreq_rst_pe_id", 32'(bus_req_pe_id), 32'd0);
    check("midreq_rst_node",  32'(bus_req_node),  32'd0);
    check("midreq_rst_ready", 32'(pe_req_ready),  32'd0);
    check("midreq_rst_info",  32'(pe_info_valid), 32'd0);
    check("midreq_rst_data",  32'(pe_info_data),  32'd0);
    check("midreq_rst_outst", 32'(outst_cnt),     32'd0);
    check("midreq_rst_err",   32'(rsp_err),       32'd0);
    do_reset();
    rsp_valid = 1'b1; rsp_data = 10'h0AA;
    step();
    rsp_valid = 1'b0;
    check("post_rst_rsp_dropped", 32'(pe_info_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
